// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
// Requester ids double as last-grant encodings and read-tag ids.
package ram_arb_pkg;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-input round-robin arbiter; a tie goes to the requester granted less recently.
// Grants are combinational and forced low while reset is held.
module rr_arb_2
   import ram_arb_pkg::*;
(
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Req_A,
   input  logic i_Req_B,
   output logic o_Gnt_A,
   output logic o_Gnt_B
);

   logic last_grant;

   always_comb begin
      o_Gnt_A = ~i_Rst & i_Req_A & (~i_Req_B | (last_grant == REQ_B));
      o_Gnt_B = ~i_Rst & i_Req_B & ~o_Gnt_A;
   end

   // Reset state of B makes A the winner of the first tie.
   always_ff @(posedge i_Clk) begin
      if (i_Rst)        last_grant <= REQ_B;
      else if (o_Gnt_A) last_grant <= REQ_A;
      else if (o_Gnt_B) last_grant <= REQ_B;
   end

endmodule

// File: rtl/ram_2port_arbiter.sv
// Shares one dual-port RAM (registered read) between requesters A and B.
// Write and read ports are arbitrated independently; read data is steered back by a tag pipe.
module ram_2port_arbiter
   import ram_arb_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_A_Wr_DV,
   input  logic [AW-1:0]    i_A_Wr_Addr,
   input  logic [WIDTH-1:0] i_A_Wr_Data,
   output logic             o_A_Wr_Ack,
   input  logic             i_A_Rd_En,
   input  logic [AW-1:0]    i_A_Rd_Addr,
   output logic             o_A_Rd_Ack,
   output logic             o_A_Rd_DV,
   output logic [WIDTH-1:0] o_A_Rd_Data,
   input  logic             i_B_Wr_DV,
   input  logic [AW-1:0]    i_B_Wr_Addr,
   input  logic [WIDTH-1:0] i_B_Wr_Data,
   output logic             o_B_Wr_Ack,
   input  logic             i_B_Rd_En,
   input  logic [AW-1:0]    i_B_Rd_Addr,
   output logic             o_B_Rd_Ack,
   output logic             o_B_Rd_DV,
   output logic [WIDTH-1:0] o_B_Rd_Data,
   output logic             o_Ram_Wr_DV,
   output logic [AW-1:0]    o_Ram_Wr_Addr,
   output logic [WIDTH-1:0] o_Ram_Wr_Data,
   output logic             o_Ram_Rd_En,
   output logic [AW-1:0]    o_Ram_Rd_Addr,
   input  logic             i_Ram_Rd_DV,
   input  logic [WIDTH-1:0] i_Ram_Rd_Data
);

   logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
   tag_t [2:1] tag_pipe;

   rr_arb_2 u_wr_arb (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Req_A (i_A_Wr_DV),
      .i_Req_B (i_B_Wr_DV),
      .o_Gnt_A (wr_gnt_a),
      .o_Gnt_B (wr_gnt_b)
   );

   rr_arb_2 u_rd_arb (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Req_A (i_A_Rd_En),
      .i_Req_B (i_B_Rd_En),
      .o_Gnt_A (rd_gnt_a),
      .o_Gnt_B (rd_gnt_b)
   );

   assign o_A_Wr_Ack = wr_gnt_a;
   assign o_B_Wr_Ack = wr_gnt_b;
   assign o_A_Rd_Ack = rd_gnt_a;
   assign o_B_Rd_Ack = rd_gnt_b;

   // Tag stage 2 lines up with the RAM's registered read data.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Ram_Wr_DV <= 1'b0;
         o_Ram_Rd_En <= 1'b0;
         tag_pipe    <= '0;
      end else begin
         o_Ram_Wr_DV <= wr_gnt_a | wr_gnt_b;
         o_Ram_Rd_En <= rd_gnt_a | rd_gnt_b;
         tag_pipe    <= {tag_pipe[1], tag_t'{valid: rd_gnt_a | rd_gnt_b,
                                             id:    rd_gnt_b ? REQ_B : REQ_A}};
      end
   end

   always_ff @(posedge i_Clk) begin
      if (wr_gnt_a | wr_gnt_b) begin
         o_Ram_Wr_Addr <= wr_gnt_b ? i_B_Wr_Addr : i_A_Wr_Addr;
         o_Ram_Wr_Data <= wr_gnt_b ? i_B_Wr_Data : i_A_Wr_Data;
      end
      if (rd_gnt_a | rd_gnt_b)
         o_Ram_Rd_Addr <= rd_gnt_b ? i_B_Rd_Addr : i_A_Rd_Addr;
   end

   // Gating with reset also hides a tag that is still valid in the first reset cycle.
   assign o_A_Rd_DV   = ~i_Rst & tag_pipe[2].valid & (tag_pipe[2].id == REQ_A) & i_Ram_Rd_DV;
   assign o_B_Rd_DV   = ~i_Rst & tag_pipe[2].valid & (tag_pipe[2].id == REQ_B) & i_Ram_Rd_DV;
   assign o_A_Rd_Data = i_Ram_Rd_Data;
   assign o_B_Rd_Data = i_Ram_Rd_Data;

endmodule

// File: tb/tb_ram_2port_arbiter.sv
// Scoreboard bench: a behavioural RAM plus a reference memory and grant model that
// predict acks, RAM-side traffic and returned read data for directed and random traffic.
module tb_ram_2port_arbiter;

   localparam int W  = 16;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_wr_dv, b_wr_dv, a_rd_en, b_rd_en;
   logic [AW-1:0] a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
   logic [W-1:0]  a_wr_data, b_wr_data;
   logic          a_wr_ack, b_wr_ack, a_rd_ack, b_rd_ack, a_rd_dv, b_rd_dv;
   logic [W-1:0]  a_rd_data, b_rd_data;
   logic          ram_wr_dv, ram_rd_en, ram_rd_dv;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [W-1:0]  ram_wr_data, ram_rd_data;

   ram_2port_arbiter dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_A_Wr_DV(a_wr_dv), .i_A_Wr_Addr(a_wr_addr), .i_A_Wr_Data(a_wr_data), .o_A_Wr_Ack(a_wr_ack),
      .i_A_Rd_En(a_rd_en), .i_A_Rd_Addr(a_rd_addr), .o_A_Rd_Ack(a_rd_ack),
      .o_A_Rd_DV(a_rd_dv), .o_A_Rd_Data(a_rd_data),
      .i_B_Wr_DV(b_wr_dv), .i_B_Wr_Addr(b_wr_addr), .i_B_Wr_Data(b_wr_data), .o_B_Wr_Ack(b_wr_ack),
      .i_B_Rd_En(b_rd_en), .i_B_Rd_Addr(b_rd_addr), .o_B_Rd_Ack(b_rd_ack),
      .o_B_Rd_DV(b_rd_dv), .o_B_Rd_Data(b_rd_data),
      .o_Ram_Wr_DV(ram_wr_dv), .o_Ram_Wr_Addr(ram_wr_addr), .o_Ram_Wr_Data(ram_wr_data),
      .o_Ram_Rd_En(ram_rd_en), .o_Ram_Rd_Addr(ram_rd_addr),
      .i_Ram_Rd_DV(ram_rd_dv), .i_Ram_Rd_Data(ram_rd_data)
   );

   // Parent-side dual-port RAM with a one-cycle registered read.
   logic [W-1:0] mem [256];
   always @(posedge clk) begin
      if (ram_wr_dv) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_dv <= ram_rd_en;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: memory contents in ack order, per-port last grant, pending reads.
   typedef struct { logic [W-1:0] data; bit known; bit id; int due; } exp_t;
   exp_t          q[$];
   exp_t          e;
   logic [W-1:0]  ref_mem [256];
   bit            known [256];
   int            cyc = 0;
   bit            lastw, lastr, pw_v, pr_v;
   logic [AW-1:0] pw_addr, pr_addr;
   logic [W-1:0]  pw_data;
   int            wait_c [4];
   logic [3:0]    prev_pend;

   always @(negedge clk) begin
      bit wa, wb, ra, rb;
      logic [3:0] reqv, gntv;
      cyc++;
      if (rst) begin
         chk("rst_acks", {a_wr_ack, b_wr_ack, a_rd_ack, b_rd_ack}, 0);
         chk("rst_rd_dv", {a_rd_dv, b_rd_dv}, 0);
         lastw = 1'b1; lastr = 1'b1; pw_v = 1'b0; pr_v = 1'b0;
         q.delete();
         prev_pend = '0;
         for (int i = 0; i < 4; i++) wait_c[i] = 0;
      end else begin
         chk("ram_wr_dv", ram_wr_dv, pw_v);
         if (pw_v) begin
            chk("ram_wr_addr", ram_wr_addr, pw_addr);
            chk("ram_wr_data", ram_wr_data, pw_data);
         end
         chk("ram_rd_en", ram_rd_en, pr_v);
         if (pr_v) chk("ram_rd_addr", ram_rd_addr, pr_addr);

         while (q.size() > 0 && q[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rd_dv_missing: no DV seen, required for requester %0d at cycle %0d", q[0].id, q[0].due);
            e = q.pop_front();
         end
         if (a_rd_dv || b_rd_dv) begin
            if (q.size() == 0 || q[0].due != cyc) begin
               checks++; errors++;
               $display("FAIL rd_dv_unexpected: got DV a=%0d b=%0d at cycle %0d, required none", a_rd_dv, b_rd_dv, cyc);
            end else begin
               e = q.pop_front();
               chk("rd_dv_steer", {a_rd_dv, b_rd_dv}, e.id ? 2'b01 : 2'b10);
               if (e.known) chk("rd_data", e.id ? b_rd_data : a_rd_data, e.data);
            end
         end

         wa = a_wr_dv && (!b_wr_dv || lastw);
         wb = b_wr_dv && !wa;
         ra = a_rd_en && (!b_rd_en || lastr);
         rb = b_rd_en && !ra;
         chk("wr_ack", {a_wr_ack, b_wr_ack}, {wa, wb});
         chk("rd_ack", {a_rd_ack, b_rd_ack}, {ra, rb});

         reqv = {a_wr_dv, b_wr_dv, a_rd_en, b_rd_en};
         gntv = {wa, wb, ra, rb};
         assert ((prev_pend & ~reqv) == 4'b0) else $error("request dropped before ack");
         prev_pend = reqv & ~gntv;
         for (int i = 0; i < 4; i++) begin
            if (reqv[i] && !gntv[i]) wait_c[i]++; else wait_c[i] = 0;
            if (reqv[i]) chk("wait_bound", wait_c[i] > 1, 0);
         end

         // Reads see memory as it was before any write acked in this same cycle.
         if (ra) q.push_back('{ref_mem[a_rd_addr], known[a_rd_addr], 1'b0, cyc + 2});
         if (rb) q.push_back('{ref_mem[b_rd_addr], known[b_rd_addr], 1'b1, cyc + 2});
         if (wa) begin ref_mem[a_wr_addr] = a_wr_data; known[a_wr_addr] = 1'b1; end
         if (wb) begin ref_mem[b_wr_addr] = b_wr_data; known[b_wr_addr] = 1'b1; end

         pw_v = wa | wb;
         if (pw_v) begin
            pw_addr = wb ? b_wr_addr : a_wr_addr;
            pw_data = wb ? b_wr_data : a_wr_data;
         end
         pr_v = ra | rb;
         if (pr_v) pr_addr = rb ? b_rd_addr : a_rd_addr;
         if (wa) lastw = 1'b0; else if (wb) lastw = 1'b1;
         if (ra) lastr = 1'b0; else if (rb) lastr = 1'b1;
      end
   end

   // Driver side: values sampled at the falling edge of the cycle just finished.
   logic         s_aw, s_bw, s_ar, s_br, s_adv, s_bdv;
   logic [W-1:0] s_adat, s_bdat;

   task automatic step();
      @(negedge clk);
      s_aw = a_wr_ack; s_bw = b_wr_ack; s_ar = a_rd_ack; s_br = b_rd_ack;
      s_adv = a_rd_dv; s_bdv = b_rd_dv; s_adat = a_rd_data; s_bdat = b_rd_data;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_acked();
      if (s_aw) a_wr_dv = 1'b0;
      if (s_bw) b_wr_dv = 1'b0;
      if (s_ar) a_rd_en = 1'b0;
      if (s_br) b_rd_en = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && (a_wr_dv || b_wr_dv || a_rd_en || b_rd_en); i++) begin
         step();
         drop_acked();
      end
      chk("idle_bound", {a_wr_dv, b_wr_dv, a_rd_en, b_rd_en}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_wr_dv = 1'b0; b_wr_dv = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin
      int ops;
      a_wr_addr = '0; b_wr_addr = '0; a_rd_addr = '0; b_rd_addr = '0;
      a_wr_data = '0; b_wr_data = '0;
      do_reset();

      // 1: lone write then read of 0x10
      a_wr_dv = 1'b1; a_wr_addr = 8'h10; a_wr_data = 16'h1234;
      step(); chk("t1_wr_ack", s_aw, 1); drop_acked();
      chk("t1_ram_wr_dv", ram_wr_dv, 1);
      chk("t1_ram_wr_addr", ram_wr_addr, 8'h10);
      a_rd_en = 1'b1; a_rd_addr = 8'h10;
      step(); chk("t1_rd_ack", s_ar, 1); drop_acked();
      step(); chk("t1_dv_early", s_adv, 0);
      step(); chk("t1_rd_dv", s_adv, 1); chk("t1_rd_data", s_adat, 16'h1234); chk("t1_b_dv", s_bdv, 0);

      // 2: sustained write contention after reset alternates from A
      do_reset();
      a_wr_dv = 1'b1; a_wr_addr = 8'h30; a_wr_data = 16'h0A00;
      b_wr_dv = 1'b1; b_wr_addr = 8'h40; b_wr_data = 16'h0B00;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t2_ack_a", s_aw, (i % 2) == 0);
         chk("t2_ack_b", s_bw, (i % 2) == 1);
         if (s_aw) begin a_wr_addr = a_wr_addr + 1; a_wr_data = a_wr_data + 1; end
         if (s_bw) begin b_wr_addr = b_wr_addr + 1; b_wr_data = b_wr_data + 1; end
      end
      wait_idle();

      // 3: same-cycle read/write collision returns old data, next read new data
      a_wr_dv = 1'b1; a_wr_addr = 8'h20; a_wr_data = 16'h0001;
      step(); drop_acked();
      a_wr_dv = 1'b1; a_wr_data = 16'hBEEF;
      b_rd_en = 1'b1; b_rd_addr = 8'h20;
      step(); chk("t3_same_cycle_acks", {s_aw, s_br}, 2'b11); drop_acked();
      b_rd_en = 1'b1;
      step(); chk("t3_rd2_ack", s_br, 1); drop_acked();
      step(); chk("t3_old_dv", s_bdv, 1); chk("t3_old_data", s_bdat, 16'h0001);
      step(); chk("t3_new_dv", s_bdv, 1); chk("t3_new_data", s_bdat, 16'hBEEF);

      // 4: back-to-back reads from different requesters
      a_wr_dv = 1'b1; a_wr_addr = 8'h01; a_wr_data = 16'h1111;
      b_wr_dv = 1'b1; b_wr_addr = 8'h02; b_wr_data = 16'h2222;
      wait_idle();
      step();
      a_rd_en = 1'b1; a_rd_addr = 8'h01;
      step(); chk("t4_a_ack", s_ar, 1); drop_acked();
      b_rd_en = 1'b1; b_rd_addr = 8'h02;
      step(); chk("t4_b_ack", s_br, 1); drop_acked();
      step(); chk("t4_a_dv", {s_adv, s_bdv}, 2'b10); chk("t4_a_data", s_adat, 16'h1111);
      step(); chk("t4_b_dv", {s_adv, s_bdv}, 2'b01); chk("t4_b_data", s_bdat, 16'h2222);

      // 5: reset right after a read ack discards the read; A wins first tie after
      a_rd_en = 1'b1; a_rd_addr = 8'h10;
      step(); chk("t5_rd_ack", s_ar, 1); drop_acked();
      rst = 1'b1;
      step(); chk("t5_dv_rst1", {s_adv, s_bdv}, 0);
      step(); chk("t5_dv_rst2", {s_adv, s_bdv}, 0);
      rst = 1'b0;
      step(); chk("t5_dv_post1", {s_adv, s_bdv}, 0);
      step(); chk("t5_dv_post2", {s_adv, s_bdv}, 0);
      a_wr_dv = 1'b1; a_wr_addr = 8'h05; a_wr_data = 16'h5555;
      b_wr_dv = 1'b1; b_wr_addr = 8'h06; b_wr_data = 16'h6666;
      step(); chk("t5_tie_a", {s_aw, s_bw}, 2'b10); drop_acked();
      wait_idle();

      // 6: random concurrent traffic
      ops = 0;
      for (int s = 0; s < 6000 && ops < 1000; s++) begin
         if (!a_wr_dv && $urandom_range(0, 2) != 0) begin
            a_wr_dv = 1'b1; a_wr_addr = AW'($urandom_range(0, 15)); a_wr_data = W'($urandom); ops++;
         end
         if (!b_wr_dv && $urandom_range(0, 2) != 0) begin
            b_wr_dv = 1'b1; b_wr_addr = AW'($urandom_range(0, 15)); b_wr_data = W'($urandom); ops++;
         end
         if (!a_rd_en && $urandom_range(0, 2) != 0) begin
            a_rd_en = 1'b1; a_rd_addr = AW'($urandom_range(0, 15)); ops++;
         end
         if (!b_rd_en && $urandom_range(0, 2) != 0) begin
            b_rd_en = 1'b1; b_rd_addr = AW'($urandom_range(0, 15)); ops++;
         end
         step();
         drop_acked();
      end
      wait_idle();
      repeat (4) step();
      chk("drain", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
